// File: rtl/idv_osc_meas_ctl_if.sv
// Register-side and bank-side signals of the IDV oscillator measurement controller.
// The controller is the slave; the IDV register/TAP block (and bank output) form the master side.
interface idv_osc_meas_ctl_if #(
  parameter int unsigned CNT_W = 24,
  parameter int unsigned WIN_W = 16
);
  logic             start;
  logic             abort;
  logic [5:0]       osc_sel;
  logic [WIN_W-1:0] window;
  logic             hfbank;
  logic [63:1]      enosc;
  logic             sleep_b;
  logic             busy;
  logic             done;
  logic             err_sel;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport slave (
    input  start, abort, osc_sel, window, hfbank,
    output enosc, sleep_b, busy, done, err_sel, count, overflow
  );

  modport master (
    output start, abort, osc_sel, window, hfbank,
    input  enosc, sleep_b, busy, done, err_sel, count, overflow
  );
endinterface

// File: rtl/idv_osc_meas_ctl.sv
// IDV oscillator measurement controller: enables one bank oscillator, lets it settle,
// then counts synchronized rising edges of the bank output over a programmable window.
module idv_osc_meas_ctl #(
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned WIN_W      = 16,
  parameter int unsigned SETTLE_CYC = 8,
  parameter logic [62:0] VALID_MASK = 63'h000F_01FF_003F_FFFF
) (
  input logic               clk,
  input logic               rst_b,
  idv_osc_meas_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_DONE
  } state_e;

  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
  // One timer serves both phases; it is loaded with (length - 1) and ends at zero.
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  logic [5:0]       sel_q, sel_d;
  logic [WIN_W-1:0] window_q, window_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             sync1_q, sync2_q, hist_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [63:1]      enosc_q, enosc_d;
  logic             sleep_q, sleep_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sel_ok;
  logic             edge_det;
  logic             run_d;
  logic [WIN_W-1:0] win_ld;

  assign sel_ok   = (bus.osc_sel != 6'd0) && VALID_MASK[bus.osc_sel - 6'd1];
  assign edge_det = sync2_q & ~hist_q;
  // A zero window still measures for one cycle.
  assign win_ld   = (window_q == '0) ? '0 : (window_q - 1'b1);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    window_d = window_q;
    tmr_d    = tmr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          count_d = '0;
          ovf_d   = 1'b0;
          if (sel_ok) begin
            sel_d    = bus.osc_sel;
            window_d = bus.window;
            err_d    = 1'b0;
            tmr_d    = SETTLE_LD;
            state_d  = ST_SETTLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_SETTLE: begin
        if (tmr_q == '0) begin
          tmr_d   = TMR_W'(win_ld);
          state_d = ST_MEASURE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      ST_MEASURE: begin
        if (edge_det) begin
          if (count_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        if (tmr_q == '0) begin
          state_d = ST_DONE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end

    // Outputs are registered, so they are decoded from the next state.
    run_d   = (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
    sleep_d = run_d;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  for (genvar gi = 1; gi <= 63; gi++) begin : g_enosc
    assign enosc_d[gi] = run_d && (sel_d == 6'(gi));
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      window_q <= '0;
      tmr_q    <= '0;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      hist_q   <= 1'b1;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      enosc_q  <= '0;
      sleep_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      window_q <= window_d;
      tmr_q    <= tmr_d;
      sync1_q  <= bus.hfbank;
      sync2_q  <= sync1_q;
      hist_q   <= sync2_q;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      enosc_q  <= enosc_d;
      sleep_q  <= sleep_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.enosc    = enosc_q;
  assign bus.sleep_b  = sleep_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err_sel  = err_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;

  a_enosc_onehot : assert property (@(posedge clk) disable iff (!rst_b) $onehot0(bus.enosc));
  a_done_pulse   : assert property (@(posedge clk) disable iff (!rst_b) bus.done |=> !bus.done);
  a_sleep_match  : assert property (@(posedge clk) disable iff (!rst_b) bus.sleep_b == (|bus.enosc));

endmodule

// File: tb/tb_idv_osc_meas_ctl.sv
// Directed bench for idv_osc_meas_ctl: a default-width instance and a 4-bit counter
// instance share the same stimulus so saturation can be checked alongside true counts.
module tb_idv_osc_meas_ctl;

  logic        clk;
  logic        rst_b;
  logic        tb_start;
  logic        tb_abort;
  logic [5:0]  tb_sel;
  logic [15:0] tb_window;
  logic        tb_hf;

  int n_cmp;
  int n_bad;

  idv_osc_meas_ctl_if #(.CNT_W(24), .WIN_W(16)) bus_m ();
  idv_osc_meas_ctl_if #(.CNT_W(4),  .WIN_W(16)) bus_s ();

  assign bus_m.start   = tb_start;
  assign bus_m.abort   = tb_abort;
  assign bus_m.osc_sel = tb_sel;
  assign bus_m.window  = tb_window;
  assign bus_m.hfbank  = tb_hf;
  assign bus_s.start   = tb_start;
  assign bus_s.abort   = tb_abort;
  assign bus_s.osc_sel = tb_sel;
  assign bus_s.window  = tb_window;
  assign bus_s.hfbank  = tb_hf;

  idv_osc_meas_ctl #(.CNT_W(24), .WIN_W(16), .SETTLE_CYC(8)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus_m.slave)
  );

  idv_osc_meas_ctl #(.CNT_W(4), .WIN_W(16), .SETTLE_CYC(8)) dut_s (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus_s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bank output: low until cycle 11 after the accepting edge, then square wave.
  function automatic logic hf_wave(input int j, input int period);
    if (j < 11) return 1'b0;
    return ((j - 11) % period) < (period / 2);
  endfunction

  // Edges the controller should have counted, as visible in cycle j.
  function automatic int exp_edges(input int j, input int period, input int total);
    int n = 0;
    for (int r = 11; r + 3 <= j; r += period) begin
      if (r + 2 <= total) n++;
    end
    return n;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " enosc"},   64'(bus_m.enosc),   64'd0);
    chk({tag, " sleep_b"}, 64'(bus_m.sleep_b), 64'd0);
    chk({tag, " busy"},    64'(bus_m.busy),    64'd0);
    chk({tag, " done"},    64'(bus_m.done),    64'd0);
  endtask

  task automatic do_meas(input string name, input logic [5:0] sel, input logic [15:0] win,
                         input int period, input int exp_cnt, input int exp_cnt_s,
                         input logic exp_ovf_s);
    int total;
    int model;
    logic [62:0] en_exp;
    total  = 8 + ((win == 16'd0) ? 1 : int'(win));
    en_exp = 63'd1 << (sel - 6'd1);
    tb_sel    = sel;
    tb_window = win;
    tb_start  = 1'b1;
    step();
    tb_start = 1'b0;
    for (int j = 1; j <= total + 1; j++) begin
      model = exp_edges(j, period, total);
      if (j <= total) begin
        chk({name, " enosc"},   64'(bus_m.enosc),   64'(en_exp));
        chk({name, " sleep_b"}, 64'(bus_m.sleep_b), 64'd1);
        chk({name, " done"},    64'(bus_m.done),    64'd0);
      end else begin
        chk({name, " enosc@done"}, 64'(bus_m.enosc),   64'd0);
        chk({name, " sleep@done"}, 64'(bus_m.sleep_b), 64'd0);
        chk({name, " done"},       64'(bus_m.done),    64'd1);
        chk({name, " final count"},   64'(bus_m.count),    64'(exp_cnt));
        chk({name, " final overflow"}, 64'(bus_m.overflow), 64'd0);
        chk({name, " final count4"},   64'(bus_s.count),    64'(exp_cnt_s));
        chk({name, " final overflow4"}, 64'(bus_s.overflow), 64'(exp_ovf_s));
        chk({name, " err_sel"},        64'(bus_m.err_sel),  64'd0);
      end
      chk({name, " busy"},      64'(bus_m.busy),     64'd1);
      chk({name, " count"},     64'(bus_m.count),    64'(model));
      chk({name, " count4"},    64'(bus_s.count),    64'((model > 15) ? 15 : model));
      chk({name, " overflow4"}, 64'(bus_s.overflow), 64'(model > 15));
      tb_hf = hf_wave(j, period);
      step();
    end
    tb_hf = 1'b0;
    chk_idle_outputs({name, " after"});
    $display("meas %s: sel=%0d window=%0d period=%0d count=%0d count4=%0d ovf4=%0b",
             name, sel, win, period, bus_m.count, bus_s.count, bus_s.overflow);
  endtask

  typedef struct {
    logic [5:0]  sel;
    logic        exp_err;
    logic [62:0] exp_en;
  } sel_vec_t;

  sel_vec_t vecs [12];

  initial begin
    int dones;
    n_cmp     = 0;
    n_bad     = 0;
    rst_b     = 1'b0;
    tb_start  = 1'b0;
    tb_abort  = 1'b0;
    tb_sel    = 6'd0;
    tb_window = 16'd0;
    tb_hf     = 1'b0;

    vecs[0]  = '{6'd23, 1'b1, 63'd0};
    vecs[1]  = '{6'd1,  1'b0, 63'd1 << 0};
    vecs[2]  = '{6'd0,  1'b1, 63'd0};
    vecs[3]  = '{6'd22, 1'b0, 63'd1 << 21};
    vecs[4]  = '{6'd32, 1'b1, 63'd0};
    vecs[5]  = '{6'd33, 1'b0, 63'd1 << 32};
    vecs[6]  = '{6'd42, 1'b1, 63'd0};
    vecs[7]  = '{6'd41, 1'b0, 63'd1 << 40};
    vecs[8]  = '{6'd53, 1'b1, 63'd0};
    vecs[9]  = '{6'd49, 1'b0, 63'd1 << 48};
    vecs[10] = '{6'd52, 1'b0, 63'd1 << 51};
    vecs[11] = '{6'd5,  1'b0, 63'd1 << 4};

    // Reset state
    #12;
    chk_idle_outputs("reset");
    chk("reset err_sel",  64'(bus_m.err_sel),  64'd0);
    chk("reset count",    64'(bus_m.count),    64'd0);
    chk("reset overflow", 64'(bus_m.overflow), 64'd0);
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk_idle_outputs("post-reset");
    $display("reset: outputs idle after release");

    // Nominal measurement
    do_meas("nominal", 6'd5, 16'd100, 10, 10, 10, 1'b0);

    // Select validation table
    for (int i = 0; i < 12; i++) begin
      tb_sel    = vecs[i].sel;
      tb_window = 16'd3;
      tb_start  = 1'b1;
      step();
      tb_start = 1'b0;
      chk("sel err_sel", 64'(bus_m.err_sel), 64'(vecs[i].exp_err));
      chk("sel done",    64'(bus_m.done),    64'(vecs[i].exp_err));
      chk("sel enosc",   64'(bus_m.enosc),   64'(vecs[i].exp_en));
      chk("sel sleep_b", 64'(bus_m.sleep_b), 64'(!vecs[i].exp_err));
      chk("sel busy",    64'(bus_m.busy),    64'd1);
      chk("sel count",   64'(bus_m.count),   64'd0);
      if (!vecs[i].exp_err) tb_abort = 1'b1;
      step();
      tb_abort = 1'b0;
      chk_idle_outputs("sel next");
      chk("sel err held", 64'(bus_m.err_sel), 64'(vecs[i].exp_err));
      $display("sel %0d: err_sel=%0b enosc=0x%0h", vecs[i].sel, vecs[i].exp_err, vecs[i].exp_en);
    end

    // Saturation boundaries on the 4-bit instance and zero/one windows
    do_meas("sat15",  6'd5, 16'd62,  4, 15, 15, 1'b0);
    do_meas("sat16",  6'd5, 16'd66,  4, 16, 15, 1'b1);
    do_meas("sat200", 6'd5, 16'd200, 4, 49, 15, 1'b1);
    do_meas("win0",   6'd5, 16'd0,  10, 0, 0, 1'b0);
    do_meas("win1",   6'd5, 16'd1,  10, 0, 0, 1'b0);

    // Abort at MEASURE cycle 20
    tb_sel    = 6'd5;
    tb_window = 16'd100;
    tb_start  = 1'b1;
    step();
    tb_start = 1'b0;
    for (int j = 1; j <= 28; j++) begin
      tb_hf = hf_wave(j, 10);
      if (j == 28) tb_abort = 1'b1;
      step();
    end
    tb_abort = 1'b0;
    chk_idle_outputs("abort");
    chk("abort count", 64'(bus_m.count), 64'd2);
    dones = 0;
    for (int j = 29; j < 150; j++) begin
      tb_hf = hf_wave(j, 10);
      step();
      if (bus_m.done) dones++;
    end
    tb_hf = 1'b0;
    chk("abort no done",    64'(dones),         64'd0);
    chk("abort count held", 64'(bus_m.count),   64'd2);
    chk("abort enosc held", 64'(bus_m.enosc),   64'd0);
    $display("abort: count=%0d busy=%0b", bus_m.count, bus_m.busy);

    // Start held high while busy: restart only from IDLE after done
    tb_sel    = 6'd5;
    tb_window = 16'd5;
    tb_start  = 1'b1;
    step();
    for (int j = 1; j <= 16; j++) begin
      if (j <= 13) begin
        chk("hold busy",  64'(bus_m.busy),  64'd1);
        chk("hold done",  64'(bus_m.done),  64'd0);
        chk("hold enosc", 64'(bus_m.enosc), 64'd1 << 4);
      end else if (j == 14) begin
        chk("hold done@14",  64'(bus_m.done),  64'd1);
        chk("hold enosc@14", 64'(bus_m.enosc), 64'd0);
      end else if (j == 15) begin
        chk_idle_outputs("hold idle@15");
      end else begin
        chk("hold restart busy",  64'(bus_m.busy),  64'd1);
        chk("hold restart enosc", 64'(bus_m.enosc), 64'd1 << 4);
        chk("hold restart done",  64'(bus_m.done),  64'd0);
      end
      if (j < 16) step();
    end
    tb_start = 1'b0;
    tb_abort = 1'b1;
    step();
    tb_abort = 1'b0;
    chk_idle_outputs("hold abort");
    $display("start-hold: second measurement began after done");

    // Asynchronous reset mid-MEASURE
    tb_sel    = 6'd5;
    tb_window = 16'd100;
    tb_start  = 1'b1;
    step();
    tb_start = 1'b0;
    for (int j = 1; j <= 50; j++) begin
      tb_hf = hf_wave(j, 10);
      if (j < 50) step();
    end
    chk("pre-reset enosc", 64'(bus_m.enosc), 64'd1 << 4);
    chk("pre-reset count", 64'(bus_m.count), 64'd4);
    #2;
    rst_b = 1'b0;
    #1;
    chk_idle_outputs("async reset");
    chk("async reset count",    64'(bus_m.count),    64'd0);
    chk("async reset overflow", 64'(bus_m.overflow), 64'd0);
    chk("async reset err_sel",  64'(bus_m.err_sel),  64'd0);
    tb_hf = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    dones = 0;
    for (int j = 0; j < 120; j++) begin
      step();
      if (bus_m.done) dones++;
    end
    chk("reset no done",   64'(dones),        64'd0);
    chk("reset count",     64'(bus_m.count),  64'd0);
    chk_idle_outputs("reset after");
    $display("async reset: outputs cleared, no done afterwards");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
